// File: rtl/ppu_reg_bridge.sv
// ppu_reg_bridge
// Bridges CPU bus accesses in $2000-$3FFF (mirrored every 8 bytes) onto the
// PPU register file. Each decoded CPU cycle becomes exactly one single-cycle
// ppu_wr or ppu_rd pulse, issued in the cycle after a clk_ppu strobe seen
// while m2 is high. Read data is returned on cpu_din.
//
// Optional feature: define PPU_BRIDGE_OPENBUS_EN to enable the open-bus latch.
// With it, reads of write-only registers (index 0,1,3,5,6) do not pulse
// ppu_rd and return the latch value instead.

module ppu_reg_bridge #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_ppu8,
    input  logic              rst,
    input  logic              clk_ppu,
    input  logic              m2,
    input  logic              rst_cpu,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    input  logic [7:0]        ppu_rdata,
    output logic [2:0]        ppu_sel,
    output logic              ppu_wr,
    output logic              ppu_rd,
    output logic [7:0]        ppu_wdata,
    output logic              err_miss
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FIRE,
        HOLD
    } state_t;

    state_t state;
    logic   m2_q;
    logic   lat_rw;
    logic   cs;
    logic   m2_rise;
    logic   addr_unused;

`ifdef PPU_BRIDGE_OPENBUS_EN
    logic [7:0] ob_latch;
    logic       sel_wo;
`endif

    // Address decode and m2 rising-edge detect
    always_comb begin
        cs      = (cpu_addr[ADDR_W-1 -: 3] == 3'b001);
        m2_rise = m2 & ~m2_q;
    end

    // Address bits between the register index and the chip-select field are
    // don't-care because of the 8-byte mirroring.
    assign addr_unused = ^cpu_addr[ADDR_W-4:3];

`ifdef PPU_BRIDGE_OPENBUS_EN
    // Write-only register indices: 0,1,3,5,6
    always_comb begin
        sel_wo = 1'b0;
        case (ppu_sel)
            3'd0, 3'd1, 3'd3, 3'd5, 3'd6: sel_wo = 1'b1;
            default:                      sel_wo = 1'b0;
        endcase
    end
`endif

    // Access sequencer: latch on m2 rise, wait for a PPU strobe, fire once,
    // then hold until m2 drops so the same window cannot fire twice.
    always_ff @(posedge clk_ppu8) begin
        if (rst) begin
            state     <= IDLE;
            m2_q      <= 1'b0;
            lat_rw    <= 1'b0;
            cpu_din   <= '0;
            ppu_sel   <= '0;
            ppu_wdata <= '0;
            ppu_wr    <= 1'b0;
            ppu_rd    <= 1'b0;
            err_miss  <= 1'b0;
`ifdef PPU_BRIDGE_OPENBUS_EN
            ob_latch  <= '0;
`endif
        end else begin
            m2_q <= m2;
            case (state)
                IDLE: begin
                    if (m2_rise && cs && !rst_cpu) begin
                        ppu_sel   <= cpu_addr[2:0];
                        lat_rw    <= cpu_rw;
                        ppu_wdata <= cpu_dout;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (rst_cpu) begin
                        state <= IDLE;
                    end else if (clk_ppu && m2) begin
                        if (lat_rw) begin
`ifdef PPU_BRIDGE_OPENBUS_EN
                            ppu_rd <= ~sel_wo;
`else
                            ppu_rd <= 1'b1;
`endif
                        end else begin
                            ppu_wr <= 1'b1;
                        end
                        state <= FIRE;
                    end else if (!m2) begin
                        err_miss <= 1'b1;
                        state    <= IDLE;
                    end
                end

                FIRE: begin
                    ppu_wr <= 1'b0;
                    ppu_rd <= 1'b0;
                    if (lat_rw) begin
`ifdef PPU_BRIDGE_OPENBUS_EN
                        if (sel_wo) begin
                            cpu_din <= ob_latch;
                        end else begin
                            cpu_din  <= ppu_rdata;
                            ob_latch <= ppu_rdata;
                        end
`else
                        cpu_din <= ppu_rdata;
`endif
                    end else begin
`ifdef PPU_BRIDGE_OPENBUS_EN
                        ob_latch <= ppu_wdata;
`endif
                    end
                    state <= HOLD;
                end

                HOLD: begin
                    if (!m2) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_reg_bridge.sv
// tb_ppu_reg_bridge
// Directed bench for ppu_reg_bridge. Expected PPU transactions (kind, index,
// data, cycle of the strobe) are queued when a CPU access is driven and
// popped by a monitor when ppu_wr/ppu_rd appears.
// Build with +define+PPU_BRIDGE_OPENBUS_EN to also exercise open-bus reads.

module tb_ppu_reg_bridge;

    logic        clk_ppu8 = 1'b0;
    logic        rst = 1'b1;
    logic        clk_ppu;
    logic        m2 = 1'b0;
    logic        rst_cpu = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic [7:0]  ppu_rdata = '0;
    logic [2:0]  ppu_sel;
    logic        ppu_wr;
    logic        ppu_rd;
    logic [7:0]  ppu_wdata;
    logic        err_miss;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int nstrobe = 0;

    typedef struct {
        logic       wr;
        logic [2:0] sel;
        logic [7:0] data;
        int         fire;
    } exp_t;

    exp_t q[$];

    logic       pend_din = 1'b0;
    logic [7:0] pend_val = '0;

    ppu_reg_bridge #(.ADDR_W(16)) dut (
        .clk_ppu8  (clk_ppu8),
        .rst       (rst),
        .clk_ppu   (clk_ppu),
        .m2        (m2),
        .rst_cpu   (rst_cpu),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .ppu_rdata (ppu_rdata),
        .ppu_sel   (ppu_sel),
        .ppu_wr    (ppu_wr),
        .ppu_rd    (ppu_rd),
        .ppu_wdata (ppu_wdata),
        .err_miss  (err_miss)
    );

    always #5 clk_ppu8 = ~clk_ppu8;

    // Divider model: cycle counter and one-in-eight PPU strobe
    always @(posedge clk_ppu8) cnt <= cnt + 1;
    assign clk_ppu = (cnt % 8 == 0);

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe monitor: pops the scoreboard and checks kind, index, data, timing
    always @(negedge clk_ppu8) begin
        if (pend_din) begin
            chk8("cpu_din_next", cpu_din, pend_val);
            pend_din = 1'b0;
        end
        if (ppu_wr || ppu_rd) begin
            exp_t e;
            nstrobe++;
            chki("strobe_excl", int'(ppu_wr & ppu_rd), 0);
            chki("strobe_m2", int'(m2), 1);
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed=wr%0b/rd%0b expected=none", ppu_wr, ppu_rd);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chki("strobe_kind_wr", int'(ppu_wr), int'(e.wr));
                chki("strobe_sel", int'(ppu_sel), int'(e.sel));
                chki("strobe_cycle", cnt, e.fire);
                if (e.wr) begin
                    chk8("strobe_wdata", ppu_wdata, e.data);
                end else begin
                    pend_din = 1'b1;
                    pend_val = e.data;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_ppu8);
        #1;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 8; i++) begin
            step();
            if (cnt % 8 == ph) break;
        end
    endtask

    // One CPU cycle: m2 high for 'hi' cycles starting at strobe phase 'ph'.
    // 'push' queues the transaction the bridge is expected to issue; it must
    // fire one cycle after the first strobe strictly after the m2 rise.
    task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] d,
                          input int ph, input int hi, input logic push);
        exp_t e;
        int   rise;
        wait_phase(ph);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_dout  = rw ? 8'h00 : d;
        ppu_rdata = rw ? d : 8'hEE;
        m2        = 1'b1;
        rise      = cnt;
        if (push) begin
            e.wr   = ~rw;
            e.sel  = a[2:0];
            e.data = d;
            e.fire = rise + (8 - rise % 8) + 1;
            q.push_back(e);
        end
        repeat (hi) step();
        m2 = 1'b0;
        cpu_addr = 16'hFFFF;
        cpu_dout = 8'hA5;
        repeat (6) step();
    endtask

    initial begin
        int base;

        // Reset
        repeat (3) step();
        rst = 1'b0;
        chk8("rst_cpu_din", cpu_din, 8'h00);
        chki("rst_sel", int'(ppu_sel), 0);
        chk8("rst_wdata", ppu_wdata, 8'h00);
        chki("rst_wr", int'(ppu_wr), 0);
        chki("rst_rd", int'(ppu_rd), 0);
        chki("rst_err", int'(err_miss), 0);

        // Write $2006=3F with m2 rising at cnt 16 (coincides with a strobe)
        for (int i = 0; i < 40; i++) begin
            if (cnt == 15) break;
            step();
        end
        access(16'h2006, 1'b0, 8'h3F, 0, 12, 1'b1);
        chki("w2006_count", nstrobe, 1);

        // Read $2002 returning 80, then two non-PPU cycles must not disturb it
        access(16'h2002, 1'b1, 8'h80, 3, 12, 1'b1);
        chk8("r2002_din", cpu_din, 8'h80);
        access(16'h4016, 1'b1, 8'h11, 4, 12, 1'b0);
        chk8("r4016_hold", cpu_din, 8'h80);
        access(16'h8000, 1'b0, 8'h22, 6, 12, 1'b0);
        chk8("w8000_hold", cpu_din, 8'h80);
        chki("nonppu_count", nstrobe, 2);

        // Mirror $3FFA reads register 2
        access(16'h3FFA, 1'b1, 8'h21, 5, 12, 1'b1);
        chk8("r3ffa_din", cpu_din, 8'h21);

        // Ten back-to-back writes to $2007
        base = nstrobe;
        for (int i = 0; i < 10; i++) begin
            access(16'h2007, 1'b0, 8'(8'h40 + i), 2, 12, 1'b1);
        end
        chki("burst_count", nstrobe - base, 10);
        chki("burst_err", int'(err_miss), 0);
        chki("burst_q", q.size(), 0);

        // m2 high only two cycles between strobes: dropped, sticky error
        base = nstrobe;
        access(16'h2003, 1'b0, 8'h99, 2, 2, 1'b0);
        chki("miss_count", nstrobe - base, 0);
        chki("miss_err", int'(err_miss), 1);
        access(16'h2001, 1'b0, 8'h1E, 1, 12, 1'b1);
        chki("miss_sticky", int'(err_miss), 1);

        // Reset asserted while waiting for a strobe
        base = nstrobe;
        wait_phase(1);
        cpu_addr = 16'h2005;
        cpu_rw   = 1'b0;
        cpu_dout = 8'h77;
        m2       = 1'b1;
        step();
        step();
        rst = 1'b1;
        m2  = 1'b0;
        step();
        rst = 1'b0;
        chk8("rstw_din", cpu_din, 8'h00);
        chki("rstw_sel", int'(ppu_sel), 0);
        chk8("rstw_wdata", ppu_wdata, 8'h00);
        chki("rstw_err", int'(err_miss), 0);
        repeat (10) step();
        chki("rstw_count", nstrobe - base, 0);

        // CPU reset blocks new accesses
        rst_cpu = 1'b1;
        access(16'h2000, 1'b0, 8'h33, 3, 12, 1'b0);
        rst_cpu = 1'b0;
        chki("rstcpu_count", nstrobe - base, 0);

`ifdef PPU_BRIDGE_OPENBUS_EN
        // Open bus: write-only register read returns last bus value
        access(16'h2000, 1'b0, 8'h5A, 3, 12, 1'b1);
        base = nstrobe;
        access(16'h2005, 1'b1, 8'hC3, 4, 12, 1'b0);
        chki("ob_no_rd", nstrobe - base, 0);
        chk8("ob_din", cpu_din, 8'h5A);
`else
        // Every register read pulses ppu_rd, including write-only indices
        access(16'h2005, 1'b1, 8'hC3, 4, 12, 1'b1);
        chk8("r2005_din", cpu_din, 8'hC3);
`endif

        repeat (4) step();
        chki("final_q", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_reg_bridge.md
# ppu_reg_bridge

Simulation-side bridge between the CPU bus and the PPU register file, clocked at clk_ppu8 alongside the clock divider. It consumes the divider's `m2`, `clk_ppu` strobe and `rst_cpu` outputs. It decodes CPU accesses to $2000–$3FFF and re-issues each one as exactly one single-cycle PPU register read or write, aligned to a `clk_ppu` strobe. Read data is returned to the CPU on `cpu_din`.

## Interface
- `ADDR_W`, 16, CPU address width.
- `clk_ppu8`  in  1  master clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk_ppu`  in  1  one-cycle PPU enable strobe, period 8 `clk_ppu8` cycles.
- `m2`  in  1  CPU bus phase; high marks the data window of a CPU cycle.
- `rst_cpu`  in  1  CPU reset; while high no accesses are issued.
- `cpu_addr`  in  ADDR_W  CPU address; stable while `m2`=1.
- `cpu_rw`  in  1  1=read, 0=write.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  read data returned to CPU.
- `ppu_rdata`  in  8  PPU register read data; valid in the cycle `ppu_rd`=1.
- `ppu_sel`  out  3  PPU register index (`cpu_addr[2:0]`).
- `ppu_wr`  out  1  one-cycle write strobe.
- `ppu_rd`  out  1  one-cycle read strobe.
- `ppu_wdata`  out  8  write data, valid with `ppu_wr`.
- `err_miss`  out  1  sticky: a decoded access was dropped.

## Operation
- Decode: `cs = cpu_addr[15:13]==3'b001`. Mirroring is every 8 bytes.
- Edge detect: `m2_q` is registered. A rise is `m2 & ~m2_q`.
- FSM states: IDLE, WAIT, FIRE, HOLD.
- IDLE → WAIT: on an `m2` rise with `cs` and `~rst_cpu`. In that cycle latch `ppu_sel`, `cpu_rw` and `ppu_wdata`.
- IDLE on an `m2` rise with `~cs`: stay in IDLE, no access.
- WAIT → FIRE: on the first cycle where `clk_ppu`=1 and `m2`=1.
- WAIT → IDLE on `m2` fall with no strobe seen: drop the access and set `err_miss`.
- FIRE: assert exactly one of `ppu_wr` or `ppu_rd` for one cycle.
  - On a read, `cpu_din <= ppu_rdata` at the end of the FIRE cycle.
  - Go to HOLD.
- HOLD → IDLE when `m2`=0. No second access is issued within the same `m2`-high window.
- `rst_cpu`=1 in WAIT: return to IDLE, no strobe, `err_miss` not set.
- `rst_cpu`=1 in FIRE: the strobe still completes.
- `cpu_din` holds its last value until the next completed read. Writes do not change it unless open-bus is enabled.
- Data not latched: `cpu_addr`/`cpu_dout` changes after the `m2` rise are ignored.

## Timing
- Reset values: `cpu_din`=8'h00, `ppu_sel`=0, `ppu_wdata`=0, `ppu_wr`=0, `ppu_rd`=0, `err_miss`=0, FSM=IDLE, `m2_q`=0.
- `rst` has priority over everything, including mid-access; any pending access is discarded.
- Latency from the `m2` rise cycle N to the strobe: first `clk_ppu` in N+1..N+8. The nominal maximum is 8 cycles.
- `cpu_din` is updated at the edge ending FIRE and is visible in cycle FIRE+1, which is before `m2` falls.
- Strobes are mutually exclusive. At most one strobe per `m2`-high window.
- Back-to-back CPU cycles, one access every 24 `clk_ppu8` cycles, are each serviced.
- `m2` rise coinciding with `clk_ppu`: that strobe is not used. Firing waits for the next strobe 8 cycles later.

## Configuration
- `PPU_BRIDGE_OPENBUS_EN` defined:
  - An 8-bit open-bus latch is updated by every completed write (with `ppu_wdata`) and every completed read.
  - Reads of write-only registers (`ppu_sel` ∈ {0,1,3,5,6}) do not assert `ppu_rd`.
  - For these reads, `cpu_din` takes the latch value in the FIRE cycle.
- Not defined:
  - All reads assert `ppu_rd` and take `ppu_rdata`.
  - Writes never touch `cpu_din`.

## Test plan
- Write $2006=8'h3F: `m2` rises at cnt 16, decoded index 6 → `ppu_wr`=1 with `ppu_sel`=6 and `ppu_wdata`=3F for exactly one cycle, on a `clk_ppu` strobe, while `m2` is high. `ppu_rd` stays 0.
- Read $2002 with `ppu_rdata`=8'h80 in the strobe cycle → exactly one `ppu_rd`. `cpu_din`=80 in the next cycle and held through the following two non-PPU CPU cycles.
- Mirror address $3FFA read → `ppu_sel`=2. Address $4016 read → no strobes, `cpu_din` unchanged.
- 10 consecutive CPU cycles to $2007 → exactly 10 `ppu_wr` pulses, none duplicated, `err_miss`=0.
- Force `m2` high for only 2 cycles between strobes → no strobe, `err_miss`=1 and sticky until `rst`.
- Assert `rst` in WAIT → all outputs at reset values next cycle, no strobe. With `rst_cpu`=1, a $2000 write → no `ppu_wr`.
- With `PPU_BRIDGE_OPENBUS_EN`: write $2000=5A, then read $2005 → `ppu_rd`=0, `cpu_din`=5A.
